// File: rtl/apb_fb_writer.sv
// apb_fb_writer: pushes one 64-pixel burst (32 words of two RGB565 pixels)
// into a HyperRAM bridge over APB3. After the data window come mask0, mask1
// and finally the destination address, because the address write is what
// kicks off the bridge. The bridge status register is then polled until it
// reports idle.
module apb_fb_writer #(
    parameter int POLL_GAP = 16,   // idle cycles before the first status poll (>= 1)
    parameter int POLL_MAX = 1024  // status polls allowed before giving up
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [21:0] dst_addr,
    input  logic [31:0] mask0,
    input  logic [31:0] mask1,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [7:0]  paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_GAP, S_PSETUP, S_PACCESS, S_FIN
    } state_t;

    state_t          state;
    logic [5:0]      k;          // write step: 0..31 data, 32 mask0, 33 mask1, 34 address
    logic [GW-1:0]   gap_cnt;
    logic [PW-1:0]   poll_cnt;   // completed status polls in this burst
    logic [21:0]     lat_dst;
    logic [31:0]     lat_m0;
    logic [31:0]     lat_m1;
    logic [7:0]      fetch_addr;
    logic [31:0]     fetch_data;
    logic            unused_prdata;

    assign unused_prdata = ^prdata[31:1];
    assign pprot         = 3'b000;
    // Pixel words are only consumed while waiting in FETCH for a data step.
    assign src_ready     = (state == S_FETCH) && (k < 6'd32);

    // Address/data of the next write as a function of the step counter.
    always_comb begin
        fetch_addr = {k[4:0], 2'b00};
        fetch_data = src_data;
        case (k)
            6'd32:   begin fetch_addr = 8'h84; fetch_data = lat_m0;           end
            6'd33:   begin fetch_addr = 8'h88; fetch_data = lat_m1;           end
            6'd34:   begin fetch_addr = 8'h80; fetch_data = {10'b0, lat_dst}; end
            default: ;
        endcase
    end

    // Burst sequencer; all bus and status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= '0;
            gap_cnt  <= '0;
            poll_cnt <= '0;
            lat_dst  <= '0;
            lat_m0   <= '0;
            lat_m1   <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            pstrb    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_dst <= dst_addr;
                        lat_m0  <= mask0;
                        lat_m1  <= mask1;
                        err     <= 1'b0;
                        k       <= '0;
                        busy    <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Data steps wait for a pixel word; trailer steps go straight on.
                    if ((k >= 6'd32) || src_valid) begin
                        paddr   <= fetch_addr;
                        pwdata  <= fetch_data;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= 1'b1;
                        pstrb   <= 4'hF;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        pstrb   <= 4'h0;
                        if (pslverr) begin
                            // Abort: remaining writes (incl. the trigger) are skipped.
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else if (k == 6'd34) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            k     <= k + 6'd1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        paddr    <= 8'h80;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        pwrite   <= 1'b0;
                        pstrb    <= 4'h0;
                        poll_cnt <= '0;
                        state    <= S_PSETUP;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_PSETUP: begin
                    penable <= 1'b1;
                    state   <= S_PACCESS;
                end
                S_PACCESS: begin
                    if (pready) begin
                        penable <= 1'b0;
                        if (pslverr || (prdata[0] && (poll_cnt == PW'(POLL_MAX - 1)))) begin
                            psel  <= 1'b0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else if (!prdata[0]) begin
                            psel  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            // Bridge still busy: back-to-back re-poll, psel stays up.
                            poll_cnt <= poll_cnt + 1'b1;
                            state    <= S_PSETUP;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fb_writer.sv
// Directed bench for apb_fb_writer: stimulus pushes the expected APB
// transfers into a queue, a negedge slave/monitor pops and compares them.
module tb_apb_fb_writer;
    localparam int POLL_GAP = 16;
    localparam int POLL_MAX = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [21:0] dst_addr = '0;
    logic [31:0] mask0 = '0, mask1 = '0;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic        busy, done, err;

    apb_fb_writer #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dst_addr(dst_addr),
        .mask0(mask0), .mask1(mask1), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic wr; logic [31:0] data; } xact_t;
    xact_t exp_q[$];

    int n_vec = 0, n_bad = 0, cyc = 0, n_reads = 0;
    // slave behaviour knobs
    logic [7:0] stall_addr = 8'hFF;
    int         stall_n = 0;
    logic [7:0] err_addr = 8'hFF;
    int         polls_busy = 0;
    // monitor state
    int         acc_cyc = 0;
    logic [7:0] hold_addr;
    logic [31:0] hold_data;
    bit         gap_arm = 0;
    int         gap_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave response + transfer monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        xact_t e;
        cyc++;
        if (psel && penable) begin
            if (acc_cyc == 0) begin
                hold_addr = paddr;
                hold_data = pwdata;
            end else begin
                chk("hold_paddr", paddr, hold_addr);
                chk("hold_pwdata", pwdata, hold_data);
            end
            pready  = (pwrite && paddr == stall_addr) ? (acc_cyc >= stall_n) : 1'b1;
            pslverr = pready && pwrite && (paddr == err_addr);
            prdata  = {31'd0, polls_busy > 0};
            if (pready) begin
                if (pwrite && paddr == stall_addr) chk("penable_len", acc_cyc + 1, stall_n + 1);
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_xfer: got addr %h wr %b, expected none", paddr, pwrite);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_addr", paddr, e.addr);
                    chk("xfer_wr", pwrite, e.wr);
                    chk("xfer_strb", pstrb, e.wr ? 4'hF : 4'h0);
                    if (e.wr) chk("xfer_data", pwdata, e.data);
                end
                if (!pwrite) begin
                    n_reads++;
                    if (polls_busy > 0) polls_busy--;
                end
                if (pwrite && paddr == 8'h80) begin gap_arm = 1; gap_start = cyc; end
                acc_cyc = 0;
            end else begin
                acc_cyc++;
            end
        end else begin
            pready = 1'b0; pslverr = 1'b0; prdata = '0; acc_cyc = 0;
            if (psel && !pwrite && gap_arm) begin
                chk("gap_len", cyc - gap_start - 1, POLL_GAP);
                gap_arm = 0;
            end
        end
    end

    task automatic push_burst(input logic [21:0] da, input logic [31:0] m0, input logic [31:0] m1,
                              input int last_k, input int nrd);
        xact_t x;
        for (int k = 0; k <= last_k; k++) begin
            x.wr = 1'b1;
            if (k < 32)       begin x.addr = 8'(k * 4); x.data = 32'hA000_0000 + k; end
            else if (k == 32) begin x.addr = 8'h84; x.data = m0; end
            else if (k == 33) begin x.addr = 8'h88; x.data = m1; end
            else              begin x.addr = 8'h80; x.data = {10'b0, da}; end
            exp_q.push_back(x);
        end
        for (int r = 0; r < nrd; r++) begin
            x.addr = 8'h80; x.wr = 1'b0; x.data = '0;
            exp_q.push_back(x);
        end
    endtask

    task automatic run_burst(input logic [21:0] da, input logic [31:0] m0, input logic [31:0] m1,
                             input int stall_word, input int stall_len, input bit stray);
        int i = 0, stall_left = stall_len, guard = 0;
        n_reads = 0;
        @(negedge clk);
        start = 1'b1; dst_addr = da; mask0 = m0; mask1 = m1; src_valid = 1'b0;
        while (i < 32 && guard < 2000) begin
            @(negedge clk);
            start = 1'b0; guard++;
            if (stray && i == 10) begin start = 1'b1; dst_addr = 22'h3FFFFF; end
            if (src_ready && i == stall_word && stall_left > 0) begin
                src_valid = 1'b0;
                chk("stall_psel", psel, 1'b0);
                stall_left--;
            end else begin
                src_valid = 1'b1;
                src_data  = 32'hA000_0000 + i;
                if (src_ready) i++;
            end
        end
        if (guard >= 2000) begin
            n_vec++; n_bad++;
            $display("FAIL feed_timeout: got %0d words, expected 32", i);
        end
    endtask

    task automatic wait_done(input bit exp_err, input int exp_reads);
        int guard = 0;
        @(negedge clk);
        src_valid = 1'b0; start = 1'b0;
        while (!done && guard < 5000) begin @(negedge clk); guard++; end
        chk("done_seen", done, 1'b1);
        chk("err_at_done", err, exp_err);
        chk("busy_in_fin", busy, 1'b1);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("err_hold", err, exp_err);
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("read_count", n_reads, exp_reads);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_psel", {psel, penable, pwrite, src_ready}, 4'h0);
        chk("rst_paddr", paddr, 8'h00);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb_pprot", {pstrb, pprot}, 7'h0);
        chk("rst_status", {busy, done, err}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // basic burst, plus an ignored start mid-burst
        push_burst(22'h000100, 32'h1234_5678, 32'h9ABC_DEF0, 34, 1);
        run_burst(22'h000100, 32'h1234_5678, 32'h9ABC_DEF0, -1, 0, 1'b1);
        wait_done(1'b0, 1);

        // source stall before word 5
        push_burst(22'h2ABCDE, 32'hFFFF_0000, 32'h0000_FFFF, 34, 1);
        run_burst(22'h2ABCDE, 32'hFFFF_0000, 32'h0000_FFFF, 5, 10, 1'b0);
        wait_done(1'b0, 1);

        // wait states on write k=7
        stall_addr = 8'h1C; stall_n = 3;
        push_burst(22'h00_0040, 32'h0, 32'hFFFF_FFFF, 34, 1);
        run_burst(22'h00_0040, 32'h0, 32'hFFFF_FFFF, -1, 0, 1'b0);
        wait_done(1'b0, 1);
        stall_addr = 8'hFF; stall_n = 0;

        // bridge busy for 5 polls
        polls_busy = 5;
        push_burst(22'h1F_0001, 32'h5555_AAAA, 32'hAAAA_5555, 34, 6);
        run_burst(22'h1F_0001, 32'h5555_AAAA, 32'hAAAA_5555, -1, 0, 1'b0);
        wait_done(1'b0, 6);

        // slave error on mask1 write: no trigger write, no polls
        err_addr = 8'h88;
        push_burst(22'h00_0200, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 33, 0);
        run_burst(22'h00_0200, 32'h0F0F_0F0F, 32'hF0F0_F0F0, -1, 0, 1'b0);
        wait_done(1'b1, 0);
        err_addr = 8'hFF;

        // bridge never goes idle
        polls_busy = 100000;
        push_burst(22'h3F_FFFF, 32'h1, 32'h2, 34, POLL_MAX);
        run_burst(22'h3F_FFFF, 32'h1, 32'h2, -1, 0, 1'b0);
        wait_done(1'b1, POLL_MAX);
        polls_busy = 0;

        // asynchronous reset in the middle of an ACCESS phase
        stall_addr = 8'h00; stall_n = 5;
        push_burst(22'h000100, 32'h0, 32'h0, 34, 1);
        @(negedge clk);
        start = 1'b1; dst_addr = 22'h000100;
        @(negedge clk);
        start = 1'b0; src_valid = 1'b1; src_data = 32'hA000_0000;
        guard = 0;
        while (!(psel && penable) && guard < 50) begin @(negedge clk); guard++; end
        chk("reached_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {psel, penable, pwrite, src_ready}, 4'h0);
        chk("arst_paddr", paddr, 8'h00);
        chk("arst_pwdata", pwdata, 32'h0);
        chk("arst_pstrb", pstrb, 4'h0);
        chk("arst_status", {busy, done, err}, 3'b000);
        src_valid = 1'b0;
        exp_q.delete();
        stall_addr = 8'hFF; stall_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {busy, psel}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
